dpram_loader: RTL
=================

// Module: dpram_loader
// PURPOSE
//  Write-side feeder for port A of the dual-port RAM. After reset, or on request, it sweeps the whole RAM to a fill value.
//  It then streams MiSTer ioctl download bytes into the RAM through a small FIFO.
//  While it owns port A it asserts cpu_hold so the Z80 side is muxed off. Outputs connect straight to ram_cs/wren_a/address_a/data_a.
// PARAMETERS
//  data_width_g  8    RAM word width; also ioctl_dout width
//  addr_width_g  14   RAM address width (2**addr_width_g words)
//  fifo_depth_g  4    ioctl FIFO entries; power of 2, >=2
//  fill_value_g  0    word written during a clear sweep
// PORTS
//  clock          in   1             single clock, shared with RAM port A
//  reset          in   1             synchronous, active-high
//  ioctl_download in   1             download session active (level)
//  ioctl_wr       in   1             one-cycle byte strobe
//  ioctl_addr     in   25            byte address of ioctl_dout
//  ioctl_dout     in   data_width_g  download byte
//  ioctl_wait     out  1             backpressure to the HPS
//  clear_req      in   1             pulse: request a full clear sweep
//  ram_cs         out  1             RAM chip select (high = port A owned by loader)
//  wren_a         out  1             RAM write enable
//  address_a      out  addr_width_g  RAM address
//  data_a         out  data_width_g  RAM write data
//  cpu_hold       out  1             high while in CLEAR, LOAD or FLUSH
//  load_done      out  1             one-cycle pulse when the FIFO has drained after a download
//  overflow       out  1             sticky: byte dropped (FIFO full or address out of range)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=CLEAR, sweep counter=0, FIFO empty, overflow=0, load_done=0, wren_a=0, address_a=0, data_a=0.
//   Also at reset: ram_cs=1, cpu_hold=1, ioctl_wait=1. Asserting reset mid-sweep or mid-load aborts and restarts CLEAR; queued bytes are lost.
//  All outputs are registered.
//  FSM:
//   CLEAR: each cycle drives wren_a=1, address_a=cnt, data_a=fill_value_g, then cnt++.
//    On the write to cnt = 2**addr_width_g-1: cnt wraps to 0 and next state is IDLE.
//    Total is exactly 2**addr_width_g writes, one per cycle, no gaps. ioctl_wait=1 throughout.
//    ioctl_wr during CLEAR is dropped and sets overflow.
//   IDLE: ram_cs=0, wren_a=0, cpu_hold=0, ioctl_wait=0.
//    Priority: clear_req -> CLEAR; ioctl_download=1 -> LOAD.
//   LOAD: ioctl_wr pushes {ioctl_addr[addr_width_g-1:0], ioctl_dout} into the FIFO.
//    If the FIFO is non-empty, one entry pops per cycle and is written 1 cycle later: wren_a=1, address/data from the entry.
//    The pop is the cycle after the push at the earliest, so push-to-write latency is 2 cycles.
//    ioctl_download falling -> FLUSH. clear_req is ignored in LOAD and FLUSH.
//   FLUSH: keeps popping. On the cycle the last write is issued with the FIFO empty, load_done pulses and next state is IDLE.
//    If the FIFO is already empty on entry, load_done pulses on the entry cycle.
//  Address range: a push with ioctl_addr >= 2**addr_width_g is discarded, not pushed, and sets overflow.
//  FIFO:
//   ioctl_wait = (count >= fifo_depth_g-1), registered, giving the HPS one cycle of slack.
//   Push when count == fifo_depth_g: dropped, overflow=1.
//   Simultaneous push and pop: count is unchanged; the write order is strictly FIFO.
//   Pointers wrap modulo fifo_depth_g.
//  overflow clears only on reset or on entry to LOAD.
//  wren_a is never high unless ram_cs is high. address_a and data_a hold their last value when wren_a=0.
// TESTING
//  Use addr_width_g=4, fill_value_g=8'hA5.
//  1. Reset, release -> exactly 16 consecutive writes, addr 0..15, data A5; then IDLE; cpu_hold falls the cycle after the addr-15 write.
//  2. In IDLE: download, wr at addr 3,4,5 with data 11,22,33 -> writes in that order, each 2 cycles after its strobe; download low -> load_done pulses once; overflow=0.
//  3. 6 back-to-back strobes, depth 4, no pop stalls -> ioctl_wait rises once count>=3. Every byte written; none dropped while the HPS honours wait.
//  4. Strobe with ioctl_addr=16 -> no RAM write, overflow=1; a later strobe at addr 2 is still written.
//  5. reset asserted mid-LOAD with 2 bytes queued -> no further loaded writes; a full 16-word A5 sweep follows.
//  6. clear_req in IDLE while ioctl_download=1 on the same cycle -> CLEAR wins; LOAD is entered after the sweep.

Source files
------------

// File: rtl/dpram_loader.sv
// Port-A feeder for the dual-port RAM: a full clear sweep after reset or on request,
// then ioctl download bytes streamed through a small FIFO. dbg_state: 0=CLEAR 1=IDLE 2=LOAD 3=FLUSH.
module dpram_loader #(
  parameter int                      data_width_g = 8,
  parameter int                      addr_width_g = 14,
  parameter int                      fifo_depth_g = 4,
  parameter logic [data_width_g-1:0] fill_value_g = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [data_width_g-1:0] ioctl_dout,
  output logic                    ioctl_wait,
  input  logic                    clear_req,
  output logic                    ram_cs,
  output logic                    wren_a,
  output logic [addr_width_g-1:0] address_a,
  output logic [data_width_g-1:0] data_a,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    overflow,
  output logic [1:0]              dbg_state
);

  localparam int PW = (fifo_depth_g > 1) ? $clog2(fifo_depth_g) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(fifo_depth_g);
  localparam logic [CW-1:0] WAIT_C = CW'(fifo_depth_g - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                  r_state;
  logic [addr_width_g-1:0] r_cnt;
  logic [addr_width_g-1:0] r_fifo_addr [fifo_depth_g];
  logic [data_width_g-1:0] r_fifo_data [fifo_depth_g];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic                    r_ram_cs;
  logic                    r_wren;
  logic [addr_width_g-1:0] r_addr;
  logic [data_width_g-1:0] r_data;
  logic                    r_cpu_hold;
  logic                    r_load_done;
  logic                    r_overflow;
  logic                    r_wait;

  logic                    w_in_range;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic [CW-1:0]           w_count_nxt;

  // Byte handshake: ioctl_wr is a one-cycle valid; ioctl_wait is a registered not-ready
  // raised one entry early, so a strobe issued the cycle wait rises still fits.
  always_comb begin
    w_in_range  = (ioctl_addr >> addr_width_g) == 25'd0;
    w_full      = (r_count == FULL_C);
    w_empty     = (r_count == '0);
    w_push      = (r_state == S_LOAD) && ioctl_wr && w_in_range && !w_full;
    w_drop      = ioctl_wr && ((r_state == S_CLEAR) ||
                               ((r_state == S_LOAD) && (!w_in_range || w_full)));
    w_pop       = ((r_state == S_LOAD) || (r_state == S_FLUSH)) && !w_empty;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ioctl_addr[addr_width_g-1:0];
      r_fifo_data[r_wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ram_cs    <= 1'b1;
      r_wren      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
      r_wait      <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        S_CLEAR: begin
          r_ram_cs    <= 1'b1;
          r_cpu_hold  <= 1'b1;
          r_wait      <= 1'b1;
          r_load_done <= 1'b0;
          r_wren      <= 1'b1;
          r_addr      <= r_cnt;
          r_data      <= fill_value_g;
          if (r_cnt == {addr_width_g{1'b1}}) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + addr_width_g'(1);
          end
        end

        S_IDLE: begin
          r_wren      <= 1'b0;
          r_load_done <= 1'b0;
          if (clear_req) begin
            r_state    <= S_CLEAR;
            r_ram_cs   <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_wait     <= 1'b1;
          end else if (ioctl_download) begin
            r_state    <= S_LOAD;
            r_ram_cs   <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_wait     <= 1'b0;
            r_overflow <= 1'b0;
          end else begin
            r_ram_cs   <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_wait     <= 1'b0;
          end
        end

        default: begin
          r_ram_cs    <= 1'b1;
          r_cpu_hold  <= 1'b1;
          r_wait      <= (w_count_nxt >= WAIT_C);
          r_wren      <= w_pop;
          r_load_done <= 1'b0;
          if (w_pop) begin
            r_addr <= r_fifo_addr[r_rd_ptr];
            r_data <= r_fifo_data[r_rd_ptr];
          end
          if (r_state == S_LOAD) begin
            if (!ioctl_download) r_state <= S_FLUSH;
          end else if (r_count <= ONE_C) begin
            // Last entry (or none) leaves this cycle; no pushes happen in FLUSH.
            r_load_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ioctl_wait = r_wait;
  assign ram_cs     = r_ram_cs;
  assign wren_a     = r_wren;
  assign address_a  = r_addr;
  assign data_a     = r_data;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule
